alu_issue_queue: RTL

Instruction buffer and issue stage directly upstream of the 16-bit accumulator ALU. It accepts {opcode, operand1, operand2} triples over a valid/ready handshake and stores them in a small circular FIFO. It issues at most one triple per clock onto the ALU's opcode/input1/input2 ports. Illegal opcodes and divide-by-zero are screened and replaced by NOOP, so the accumulator is never corrupted.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_iq_fifo.sv | 55 +++++
 rtl/alu_issue_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default data width, opcode legality.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_RESET = 4'b1111;

    // Encodings 1001..1110 are unassigned; everything else is a real ALU op.
    function automatic logic is_legal_op(input logic [3:0] op);
        return !((op >= 4'b1001) && (op <= 4'b1110));
    endfunction

endpackage

// File: rtl/alu_iq_fifo.sv
// Ring buffer for the issue queue: storage, wrapping pointers, occupancy count.
module alu_iq_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic                     do_push;
    logic                     do_pop;

    // Full blocks pushes even when a pop happens on the same edge (no fall-through).
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the accumulator ALU: buffers triples, screens the head
// entry at pop time, and drives registered opcode/operands into the ALU.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             issue_en,
    input  logic             err_clear,
    output logic [3:0]       alu_opcode,
    output logic [W-1:0]     alu_input1,
    output logic [W-1:0]     alu_input2,
    output logic             alu_issued,
    output logic             empty,
    output logic             full,
    output logic             err_div0,
    output logic             err_illegal,
    output logic [CNT_W-1:0] issue_count
);

    localparam int DW = 4 + 2*W;

    logic [DW-1:0] head;
    logic [3:0]    head_op;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;
    logic          push;
    logic          pop;
    logic          sq_div0;
    logic          sq_illegal;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = issue_en && !empty;

    alu_iq_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_opcode, in_a, in_b}),
        .rdata (head),
        .empty (empty),
        .full  (full)
    );

    assign {head_op, head_a, head_b} = head;

    // Screening of the head entry; the two causes are mutually exclusive.
    assign sq_div0    = (head_op == OP_DIV) && (head_b == '0);
    assign sq_illegal = !is_legal_op(head_op);

    // ALU drive registers: a popped (possibly squashed) entry, otherwise NOOP/0/0.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= OP_NOOP;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_issued <= 1'b0;
        end else if (pop && !sq_div0 && !sq_illegal) begin
            alu_opcode <= head_op;
            alu_input1 <= head_a;
            alu_input2 <= head_b;
            alu_issued <= 1'b1;
        end else begin
            alu_opcode <= OP_NOOP;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_issued <= pop;
        end
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_div0    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            if (pop && sq_div0)    err_div0 <= 1'b1;
            else if (err_clear)    err_div0 <= 1'b0;
            if (pop && sq_illegal) err_illegal <= 1'b1;
            else if (err_clear)    err_illegal <= 1'b0;
        end
    end

    // Saturating count of popped entries, squashed ones included.
    always_ff @(posedge clk) begin
        if (rst)                          issue_count <= '0;
        else if (pop && issue_count != '1) issue_count <= issue_count + 1'b1;
    end

endmodule
